// File: rtl/cond_unit_if.sv
// Decoder-to-condition-unit bundle: per-instruction control from the decoder in,
// registered write strobes and the architectural flags out.
interface cond_unit_if;
  // Input side: valid_i marks a decoded instruction in this cycle. There is no
  // ready. stall_i=1 freezes the unit and discards whatever is on the inputs.
  // An instruction is accepted on an edge where valid_i=1 and stall_i=0.
  logic       valid_i;
  logic       stall_i;
  logic [3:0] cond;
  logic [1:0] flagW;
  logic       pcs;
  logic       regW;
  logic       memW;
  logic       noWrite;
  logic [3:0] aluFlags;

  logic       valid_o;
  logic       pcSrc;
  logic       regWrite;
  logic       memWrite;
  logic       condEx;
  logic [3:0] flags;

  modport master (
    output valid_i, stall_i, cond, flagW, pcs, regW, memW, noWrite, aluFlags,
    input  valid_o, pcSrc, regWrite, memWrite, condEx, flags
  );

  modport slave (
    input  valid_i, stall_i, cond, flagW, pcs, regW, memW, noWrite, aluFlags,
    output valid_o, pcSrc, regWrite, memWrite, condEx, flags
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution unit: gates decoder write strobes by the ARM condition
// field and owns the {N,Z,C,V} register. Optional counters: COND_UNIT_PERF_CNT_EN.
module cond_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  cond_unit_if.slave           bus,
  input  logic                 perf_clr,
  output logic [CNT_WIDTH-1:0] exec_cnt,
  output logic [CNT_WIDTH-1:0] squash_cnt
);

  logic       valid_q,     valid_d;
  logic       pc_src_q,    pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       cond_ex_q,   cond_ex_d;
  logic [3:0] flags_q,     flags_d;

  logic accept;
  logic cond_pass;

  // Evaluated against the registered flags only, so a flag-setting instruction
  // is seen by its successor one cycle later with no bypass from aluFlags.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cf;
      4'h3:    r = ~cf;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cf & ~z;
      4'h9:    r = ~cf | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign cond_pass = eval_cond(bus.cond, flags_q);
  assign accept    = bus.valid_i & ~bus.stall_i;

  always_comb begin
    valid_d     = valid_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    cond_ex_d   = cond_ex_q;
    flags_d     = flags_q;
    if (!bus.stall_i) begin
      valid_d     = bus.valid_i;
      cond_ex_d   = accept & cond_pass;
      pc_src_d    = accept & cond_pass & bus.pcs;
      reg_write_d = accept & cond_pass & bus.regW & ~bus.noWrite;
      mem_write_d = accept & cond_pass & bus.memW;
      if (accept && cond_pass) begin
        if (bus.flagW[1]) flags_d[3:2] = bus.aluFlags[3:2];
        if (bus.flagW[0]) flags_d[1:0] = bus.aluFlags[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      valid_q     <= valid_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      cond_ex_q   <= cond_ex_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.pcSrc    = pc_src_q;
  assign bus.regWrite = reg_write_q;
  assign bus.memWrite = mem_write_q;
  assign bus.condEx   = cond_ex_q;
  assign bus.flags    = flags_q;

`ifdef COND_UNIT_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] exec_cnt_q,   exec_cnt_d;
  logic [CNT_WIDTH-1:0] squash_cnt_q, squash_cnt_d;

  // Clear wins over a same-cycle increment; both counters stick at all-ones.
  always_comb begin
    exec_cnt_d   = exec_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (!bus.stall_i) begin
      if (perf_clr) begin
        exec_cnt_d   = '0;
        squash_cnt_d = '0;
      end else if (accept) begin
        if (cond_pass) begin
          if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_ONE;
        end else begin
          if (squash_cnt_q != CNT_MAX) squash_cnt_d = squash_cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else begin
      exec_cnt_q   <= exec_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign exec_cnt   = exec_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign exec_cnt        = '0;
  assign squash_cnt      = '0;
`endif

endmodule
